// File: rtl/bp_sacc_spm.sv
// Scratchpad accelerator behind the CCE-IO crossbar port: serves uncached reads and writes to a
// byte-maskable SPM and a small counter CSR bank, with one command in flight at a time.

package bp_sacc_spm_pkg;

    typedef enum logic [0:0] {e_bp_default_cfg = 1'b0} bp_cfg_e;

    typedef enum logic [2:0] {
        e_cfg_paddr,
        e_cfg_hio,
        e_cfg_lce_id,
        e_cfg_block,
        e_cfg_payload
    } cfg_field_e;

    localparam logic [3:0] msg_uc_rd_gp   = 4'd2;
    localparam logic [3:0] msg_uc_wr_gp   = 4'd3;
    localparam logic [3:0] subop_store_gp = 4'd0;

    function automatic int bp_cfg_width(input bp_cfg_e cfg, input cfg_field_e field);
        int w;
        w = 0;
        if (cfg == e_bp_default_cfg) begin
            case (field)
                e_cfg_paddr:   w = 40;
                e_cfg_hio:     w = 4;
                e_cfg_lce_id:  w = 4;
                e_cfg_block:   w = 512;
                e_cfg_payload: w = 16;
                default:       w = 0;
            endcase
        end
        return w;
    endfunction

endpackage

module bp_sacc_spm
    import bp_sacc_spm_pkg::*;
#(
    parameter bp_cfg_e bp_params_p = e_bp_default_cfg,
    parameter int els_p            = 64,
    parameter int cnt_width_p      = 64,
    localparam int paddr_width_p       = bp_cfg_width(bp_params_p, e_cfg_paddr),
    localparam int hio_width_p         = bp_cfg_width(bp_params_p, e_cfg_hio),
    localparam int lce_id_width_p      = bp_cfg_width(bp_params_p, e_cfg_lce_id),
    localparam int cce_block_width_p   = bp_cfg_width(bp_params_p, e_cfg_block),
    localparam int payload_width_p     = bp_cfg_width(bp_params_p, e_cfg_payload),
    localparam int mem_header_width_lp = payload_width_p + 3 + paddr_width_p + 4 + 4
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [lce_id_width_p-1:0]      lce_id_i,

    input  logic [mem_header_width_lp-1:0] io_cmd_header_i,
    input  logic [cce_block_width_p-1:0]   io_cmd_data_i,
    input  logic                           io_cmd_v_i,
    output logic                           io_cmd_ready_o,

    output logic [mem_header_width_lp-1:0] io_resp_header_o,
    output logic [cce_block_width_p-1:0]   io_resp_data_o,
    output logic                           io_resp_v_o,
    input  logic                           io_resp_yumi_i,

    output logic [mem_header_width_lp-1:0] io_cmd_header_o,
    output logic [cce_block_width_p-1:0]   io_cmd_data_o,
    output logic                           io_cmd_v_o,
    input  logic                           io_cmd_yumi_i,

    input  logic [mem_header_width_lp-1:0] io_resp_header_i,
    input  logic [cce_block_width_p-1:0]   io_resp_data_i,
    input  logic                           io_resp_v_i,
    output logic                           io_resp_ready_o
);

    localparam int idx_full_w_lp = paddr_width_p - hio_width_p - 3;
    localparam int idx_w_lp      = $clog2(els_p);

    typedef struct packed {
        logic [payload_width_p-1:0] payload;
        logic [2:0]                 size;
        logic [paddr_width_p-1:0]   addr;
        logic [3:0]                 subop;
        logic [3:0]                 msg_type;
    } mem_header_s;

    typedef enum logic [1:0] {e_ready, e_spm_rd, e_resp} state_e;

    // Sizes above one word are served as a full 64-bit access.
    function automatic logic [1:0] eff_size(input logic [2:0] size);
        return (size > 3'd3) ? 2'd3 : size[1:0];
    endfunction

    function automatic logic [63:0] size_mask(input logic [1:0] s);
        case (s)
            2'd0:    return 64'h0000_0000_0000_00ff;
            2'd1:    return 64'h0000_0000_0000_ffff;
            2'd2:    return 64'h0000_0000_ffff_ffff;
            default: return '1;
        endcase
    endfunction

    function automatic logic [7:0] byte_mask(input logic [1:0] s);
        case (s)
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0f;
            default: return 8'hff;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] s, input logic [2:0] off);
        case (s)
            2'd0:    return 1'b0;
            2'd1:    return off[0];
            2'd2:    return |off[1:0];
            default: return |off;
        endcase
    endfunction

    state_e      state_r, state_n;
    mem_header_s cmd_hdr, hdr_r;
    logic [63:0] data_r;
    logic [cnt_width_p-1:0] wr_cnt_r, rd_cnt_r, err_cnt_r;

    assign cmd_hdr = mem_header_s'(io_cmd_header_i);

    logic [hio_width_p-1:0]   hio;
    logic [idx_full_w_lp-1:0] idx_full;
    logic [2:0]               off;
    logic [7:0]               csr_off;
    logic [1:0]               cmd_size;

    assign hio      = cmd_hdr.addr[paddr_width_p-1 -: hio_width_p];
    assign idx_full = cmd_hdr.addr[paddr_width_p-hio_width_p-1:3];
    assign off      = cmd_hdr.addr[2:0];
    assign csr_off  = cmd_hdr.addr[7:0];
    assign cmd_size = eff_size(cmd_hdr.size);

    logic is_rd, is_wr, csr_sel, spm_sel, cmd_err, accept;
    logic spm_rd_go, spm_wr_go, csr_rd_go, clear_go, err_go;

    assign is_rd   = (cmd_hdr.msg_type == msg_uc_rd_gp);
    assign is_wr   = (cmd_hdr.msg_type == msg_uc_wr_gp);
    assign csr_sel = (hio == hio_width_p'(0));
    assign spm_sel = (hio == hio_width_p'(1));
    assign cmd_err = !(is_rd || is_wr) || !(csr_sel || spm_sel)
                   || (spm_sel && ((idx_full >= idx_full_w_lp'(els_p)) || misaligned(cmd_size, off)));

    assign accept    = io_cmd_v_i && reset_n_i && (state_r == e_ready);
    assign spm_rd_go = accept && !cmd_err && spm_sel && is_rd;
    assign spm_wr_go = accept && !cmd_err && spm_sel && is_wr;
    assign csr_rd_go = accept && !cmd_err && csr_sel && is_rd;
    assign clear_go  = accept && !cmd_err && csr_sel && is_wr && (csr_off == 8'h18) && io_cmd_data_i[0];
    assign err_go    = accept && cmd_err;

    logic [63:0] csr_rdata;
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        csr_rdata = '0;
        case (csr_off)
            8'h00:   csr_rdata = 64'(wr_cnt_r);
            8'h08:   csr_rdata = 64'(rd_cnt_r);
            8'h10:   csr_rdata = 64'(err_cnt_r);
            default: csr_rdata = '0;
        endcase
    end

    always_comb begin
        state_n     = state_r;
        io_resp_v_o = 1'b0;
        case (state_r)
            e_ready:  if (accept) state_n = spm_rd_go ? e_spm_rd : e_resp;
            e_spm_rd: state_n = e_resp;
            e_resp: begin
                io_resp_v_o = 1'b1;
                if (io_resp_yumi_i) state_n = e_ready;
            end
            default:  state_n = e_ready;
        endcase
    end

    assign io_cmd_ready_o = reset_n_i && (state_r == e_ready);

    logic [63:0] mem [els_p];
    logic [63:0] mem_q;
    logic [idx_w_lp-1:0] mem_idx;
    logic [7:0]  wmask;
    logic [63:0] wdata;

    assign mem_idx = idx_full[idx_w_lp-1:0];
    assign wmask   = byte_mask(cmd_size) << off;
    assign wdata   = (io_cmd_data_i[63:0] & size_mask(cmd_size)) << {off, 3'b000};

    // NOTE: the SRAM array is deliberately left out of reset; its contents are undefined afterwards.
    always_ff @(posedge clk_i) begin
        if (spm_wr_go) begin
            for (int b = 0; b < 8; b++) begin
                if (wmask[b]) mem[mem_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (spm_rd_go) mem_q <= mem[mem_idx];
    end

    logic [63:0] rd_aligned;
    assign rd_aligned = (mem_q >> {hdr_r.addr[2:0], 3'b000}) & size_mask(eff_size(hdr_r.size));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r   <= e_ready;
            hdr_r     <= '0;
            data_r    <= '0;
            wr_cnt_r  <= '0;
            rd_cnt_r  <= '0;
            err_cnt_r <= '0;
        end else begin
            state_r <= state_n;
            if (accept) begin
                hdr_r       <= cmd_hdr;
                hdr_r.subop <= subop_store_gp;
                data_r      <= csr_rd_go ? csr_rdata : '0;
            end else if (state_r == e_spm_rd) begin
                data_r <= rd_aligned;
            end
            // One accepted command is one operation, so a clear never coincides with an increment.
            if (clear_go) begin
                wr_cnt_r  <= '0;
                rd_cnt_r  <= '0;
                err_cnt_r <= '0;
            end else begin
                if (spm_wr_go) wr_cnt_r  <= wr_cnt_r  + cnt_width_p'(1);
                if (spm_rd_go) rd_cnt_r  <= rd_cnt_r  + cnt_width_p'(1);
                if (err_go)    err_cnt_r <= err_cnt_r + cnt_width_p'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_n_i && io_resp_yumi_i) assert (state_r == e_resp);
    end

    assign io_resp_header_o = hdr_r;
    assign io_resp_data_o   = cce_block_width_p'(data_r);
    assign io_cmd_header_o  = '0;
    assign io_cmd_data_o    = '0;
    assign io_cmd_v_o       = 1'b0;
    assign io_resp_ready_o  = 1'b1;

    logic unused_inputs;
    assign unused_inputs = ^{lce_id_i, io_cmd_data_i[cce_block_width_p-1:64], io_cmd_yumi_i,
                             io_resp_header_i, io_resp_data_i, io_resp_v_i, cmd_hdr.subop};

endmodule

// File: tb/tb_bp_sacc_spm.sv
// Directed bench for bp_sacc_spm: SPM/CSR accesses, partial writes, errors, back-pressure,
// counter clear and reset during a pending response.

module tb_bp_sacc_spm;
    import bp_sacc_spm_pkg::*;

    localparam int paddr_w = bp_cfg_width(e_bp_default_cfg, e_cfg_paddr);
    localparam int lce_w   = bp_cfg_width(e_bp_default_cfg, e_cfg_lce_id);
    localparam int block_w = bp_cfg_width(e_bp_default_cfg, e_cfg_block);
    localparam int pl_w    = bp_cfg_width(e_bp_default_cfg, e_cfg_payload);
    localparam int hdr_w   = pl_w + 3 + paddr_w + 4 + 4;
    localparam int els     = 64;

    typedef struct packed {
        logic [pl_w-1:0]    payload;
        logic [2:0]         size;
        logic [paddr_w-1:0] addr;
        logic [3:0]         subop;
        logic [3:0]         msg_type;
    } hdr_t;

    localparam logic [3:0] RD  = 4'd2;
    localparam logic [3:0] WR  = 4'd3;
    localparam logic [3:0] PRE = 4'd4;
    localparam logic [39:0] SPM = 40'h10_0000_0000;
    localparam logic [39:0] CSR = 40'h00_0000_0000;

    logic               clk_i = 1'b0;
    logic               reset_n_i = 1'b0;
    logic [lce_w-1:0]   lce_id_i = '0;
    logic [hdr_w-1:0]   io_cmd_header_i = '0;
    logic [block_w-1:0] io_cmd_data_i = '0;
    logic               io_cmd_v_i = 1'b0;
    logic               io_cmd_ready_o;
    logic [hdr_w-1:0]   io_resp_header_o;
    logic [block_w-1:0] io_resp_data_o;
    logic               io_resp_v_o;
    logic               io_resp_yumi_i = 1'b0;
    logic [hdr_w-1:0]   io_cmd_header_o;
    logic [block_w-1:0] io_cmd_data_o;
    logic               io_cmd_v_o;
    logic               io_cmd_yumi_i = 1'b0;
    logic [hdr_w-1:0]   io_resp_header_i = '0;
    logic [block_w-1:0] io_resp_data_i = '0;
    logic               io_resp_v_i = 1'b0;
    logic               io_resp_ready_o;

    bp_sacc_spm #(.els_p(els), .cnt_width_p(64)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .lce_id_i(lce_id_i),
        .io_cmd_header_i(io_cmd_header_i), .io_cmd_data_i(io_cmd_data_i),
        .io_cmd_v_i(io_cmd_v_i), .io_cmd_ready_o(io_cmd_ready_o),
        .io_resp_header_o(io_resp_header_o), .io_resp_data_o(io_resp_data_o),
        .io_resp_v_o(io_resp_v_o), .io_resp_yumi_i(io_resp_yumi_i),
        .io_cmd_header_o(io_cmd_header_o), .io_cmd_data_o(io_cmd_data_o),
        .io_cmd_v_o(io_cmd_v_o), .io_cmd_yumi_i(io_cmd_yumi_i),
        .io_resp_header_i(io_resp_header_i), .io_resp_data_i(io_resp_data_i),
        .io_resp_v_i(io_resp_v_i), .io_resp_ready_o(io_resp_ready_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;
    logic [pl_w-1:0] pl_q = 16'h0100;
    hdr_t exp_hdr;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic finish_resp(input string tag);
        io_resp_yumi_i = 1'b1;
        @(posedge clk_i); #1;
        io_resp_yumi_i = 1'b0;
        check({tag, "_v_drop"}, io_resp_v_o, 1'b0);
        check({tag, "_ready_back"}, io_cmd_ready_o, 1'b1);
    endtask

    // Caller is always at posedge+1; returns at posedge+1 with the response showing.
    task automatic transact(input string tag, input logic [3:0] msg, input logic [39:0] addr,
                            input logic [2:0] size, input logic [63:0] wdata,
                            input int exp_lat, input logic [63:0] exp_data, input bit do_yumi);
        hdr_t h;
        int n;
        n = 0;
        while (!io_cmd_ready_o && n < 20) begin
            @(posedge clk_i); #1;
            n++;
        end
        check({tag, "_ready"}, io_cmd_ready_o, 1'b1);
        pl_q = pl_q + 16'd1;
        h = '{payload: pl_q, size: size, addr: addr, subop: 4'h7, msg_type: msg};
        io_cmd_header_i = h;
        io_cmd_data_i   = block_w'(wdata);
        io_cmd_v_i      = 1'b1;
        @(posedge clk_i); #1;
        io_cmd_v_i    = 1'b0;
        io_cmd_data_i = '0;
        n = 1;
        while (!io_resp_v_o && n < 10) begin
            @(posedge clk_i); #1;
            n++;
        end
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_data"}, io_resp_data_o, block_w'(exp_data));
        exp_hdr = h;
        exp_hdr.subop = 4'h0;
        check({tag, "_header"}, io_resp_header_o, exp_hdr);
        if (do_yumi) finish_resp(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [hdr_w-1:0]   held_hdr;
        logic [block_w-1:0] held_data;

        // Reset
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_ready", io_cmd_ready_o, 1'b0);
        check("rst_v", io_resp_v_o, 1'b0);
        check("rst_hdr", io_resp_header_o, '0);
        check("rst_data", io_resp_data_o, '0);
        check("rst_cmd_v_o", io_cmd_v_o, 1'b0);
        check("rst_resp_ready_o", io_resp_ready_o, 1'b1);
        reset_n_i = 1'b1;

        // Basic write then read, CSR counts
        transact("w10", WR, SPM | 40'h10, 3'd3, 64'hDEADBEEF_CAFEF00D, 1, 64'h0, 1);
        transact("r10", RD, SPM | 40'h10, 3'd3, 64'h0, 2, 64'hDEADBEEF_CAFEF00D, 1);
        transact("csr_wr1", RD, CSR | 40'h00, 3'd3, 64'h0, 1, 64'd1, 1);
        transact("csr_rd1", RD, CSR | 40'h08, 3'd3, 64'h0, 1, 64'd1, 1);

        // Partial writes; upper data bits beyond the access size must be dropped
        transact("w20", WR, SPM | 40'h20, 3'd3, 64'h0, 1, 64'h0, 1);
        transact("w22", WR, SPM | 40'h22, 3'd1, 64'hFFFF_FFFF_FFFF_ABCD, 1, 64'h0, 1);
        transact("w27", WR, SPM | 40'h27, 3'd0, 64'hFFFF_FFFF_FFFF_FF5A, 1, 64'h0, 1);
        transact("r20", RD, SPM | 40'h20, 3'd3, 64'h0, 2, 64'h5A00_0000_ABCD_0000, 1);
        transact("r24", RD, SPM | 40'h24, 3'd2, 64'h0, 2, 64'h5A00_0000, 1);

        // Last valid word
        transact("w1f8", WR, SPM | 40'h1F8, 3'd3, 64'h0123_4567_89AB_CDEF, 1, 64'h0, 1);
        transact("r1f8", RD, SPM | 40'h1F8, 3'd3, 64'h0, 2, 64'h0123_4567_89AB_CDEF, 1);

        // Errors
        transact("e_oob", RD, SPM | 40'h200, 3'd3, 64'h0, 1, 64'h0, 1);
        transact("e_mis", WR, SPM | 40'h22, 3'd2, 64'hFFFF_FFFF, 1, 64'h0, 1);
        transact("e_hio", RD, 40'h20_0000_0010, 3'd3, 64'h0, 1, 64'h0, 1);
        transact("e_msg", PRE, SPM | 40'h10, 3'd3, 64'h1, 1, 64'h0, 1);
        transact("r20_after_err", RD, SPM | 40'h20, 3'd3, 64'h0, 2, 64'h5A00_0000_ABCD_0000, 1);
        transact("csr_unlisted", RD, CSR | 40'h20, 3'd3, 64'h0, 1, 64'h0, 1);
        transact("csr_err4", RD, CSR | 40'h10, 3'd3, 64'h0, 1, 64'd4, 1);
        transact("csr_wr_ign", WR, CSR | 40'h00, 3'd3, 64'h99, 1, 64'h0, 1);
        transact("csr_wr5", RD, CSR | 40'h00, 3'd3, 64'h0, 1, 64'd5, 1);
        transact("csr_rd5", RD, CSR | 40'h08, 3'd3, 64'h0, 1, 64'd5, 1);

        // Back-pressure on an SPM read response
        transact("bp", RD, SPM | 40'h10, 3'd3, 64'h0, 2, 64'hDEADBEEF_CAFEF00D, 0);
        held_hdr  = io_resp_header_o;
        held_data = io_resp_data_o;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_i); #1;
            check("bp_v", io_resp_v_o, 1'b1);
            check("bp_hdr", io_resp_header_o, held_hdr);
            check("bp_data", io_resp_data_o, held_data);
            check("bp_ready", io_cmd_ready_o, 1'b0);
        end
        finish_resp("bp");
        transact("b2b_w30", WR, SPM | 40'h30, 3'd3, 64'h1111, 1, 64'h0, 1);

        // Counter clear: data[0]=0 is a no-op, data[0]=1 clears
        transact("ctrl0", WR, CSR | 40'h18, 3'd3, 64'h2, 1, 64'h0, 1);
        transact("keep_wr", RD, CSR | 40'h00, 3'd3, 64'h0, 1, 64'd6, 1);
        transact("keep_rd", RD, CSR | 40'h08, 3'd3, 64'h0, 1, 64'd6, 1);
        transact("keep_err", RD, CSR | 40'h10, 3'd3, 64'h0, 1, 64'd4, 1);
        transact("ctrl_rd", RD, CSR | 40'h18, 3'd3, 64'h0, 1, 64'h0, 1);
        transact("ctrl1", WR, CSR | 40'h18, 3'd3, 64'h1, 1, 64'h0, 1);
        transact("clr_wr", RD, CSR | 40'h00, 3'd3, 64'h0, 1, 64'h0, 1);
        transact("clr_rd", RD, CSR | 40'h08, 3'd3, 64'h0, 1, 64'h0, 1);
        transact("clr_err", RD, CSR | 40'h10, 3'd3, 64'h0, 1, 64'h0, 1);

        // Reset while a response is pending
        transact("w40", WR, SPM | 40'h40, 3'd3, 64'h4040, 1, 64'h0, 1);
        transact("r40", RD, SPM | 40'h40, 3'd3, 64'h0, 2, 64'h4040, 0);
        reset_n_i = 1'b0;
        @(posedge clk_i); #1;
        check("mid_rst_v", io_resp_v_o, 1'b0);
        check("mid_rst_ready", io_cmd_ready_o, 1'b0);
        check("mid_rst_hdr", io_resp_header_o, '0);
        check("mid_rst_data", io_resp_data_o, '0);
        reset_n_i = 1'b1;
        transact("post_rst_wr", RD, CSR | 40'h00, 3'd3, 64'h0, 1, 64'h0, 1);
        transact("post_rst_rd", RD, CSR | 40'h08, 3'd3, 64'h0, 1, 64'h0, 1);
        transact("w48", WR, SPM | 40'h48, 3'd3, 64'h4848_0000_1234, 1, 64'h0, 1);
        transact("r48", RD, SPM | 40'h48, 3'd3, 64'h0, 2, 64'h4848_0000_1234, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
